// File: rtl/dsp_fe_clkdiv_multi.sv
// Multi-channel integer clock divider with per-channel run/stop
// control and a global phase-alignment strobe.
module dsp_fe_clkdiv_multi #(
  parameter int NumCh    = 4,
  parameter int DivWidth = 4
) (
  input  logic                      i_clk_ref,
  input  logic                      i_rst,
  input  logic [NumCh-1:0]          i_en,
  input  logic [NumCh*DivWidth-1:0] i_div,
  input  logic                      i_sync,
  output logic [NumCh-1:0]          o_clk,
  output logic [NumCh-1:0]          o_clk_en,
  output logic [NumCh-1:0]          o_running
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  localparam logic [DivWidth-1:0] DOne  = DivWidth'(1);
  localparam logic [DivWidth-1:0] DZero = '0;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    logic [1:0]          r_state;
    logic [1:0]          w_state_nx;
    logic [DivWidth-1:0] r_cnt;
    logic [DivWidth-1:0] w_cnt_nx;
    // Latched ratio minus one, i.e. the terminal count.
    logic [DivWidth-1:0] r_dm;
    logic [DivWidth-1:0] w_dm_nx;
    logic [DivWidth-1:0] w_div_c;
    logic [DivWidth-1:0] w_div_eff;
    logic [DivWidth:0]   w_half;
    logic                w_wrap;
    logic                w_run_nx;
    logic                w_clk_nx;
    logic                w_clk_en_nx;
    logic                r_clk;
    logic                r_clk_en;
    logic                r_run;

    assign w_div_c   = i_div[c*DivWidth +: DivWidth];
    assign w_div_eff = (w_div_c == DZero) ? DOne : w_div_c;
    assign w_wrap    = (r_cnt == r_dm);

    // Next state, count and ratio; outputs derived from next values
    always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_dm_nx    = r_dm;
      unique case (r_state)
        S_IDLE: begin
          w_cnt_nx = DZero;
          if (i_en[c]) begin
            w_state_nx = S_RUN;
            w_dm_nx    = w_div_eff;
          end
        end
        S_RUN, S_STOP: begin
          if (w_wrap || i_sync) begin
            w_cnt_nx = DZero;
            w_dm_nx  = w_div_eff;
          end else begin
            w_cnt_nx = r_cnt + DOne;
          end
          if (i_en[c]) begin
            w_state_nx = S_RUN;
          end else if (r_state == S_STOP && w_wrap) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = DZero;
          end else begin
            w_state_nx = S_STOP;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = DZero;
        end
      endcase
      w_half      = ({1'b0, w_dm_nx} + {{DivWidth{1'b0}}, 1'b1}) >> 1;
      w_run_nx    = (w_state_nx != S_IDLE);
      w_clk_nx    = w_run_nx && ({1'b0, w_cnt_nx} < w_half);
      w_clk_en_nx = w_run_nx && (w_cnt_nx == w_dm_nx);
    end

    // Channel state and registered outputs
    always_ff @(posedge i_clk_ref) begin
      if (i_rst) begin
        r_state  <= S_IDLE;
        r_cnt    <= DZero;
        r_dm     <= DOne;
        r_clk    <= 1'b0;
        r_clk_en <= 1'b0;
        r_run    <= 1'b0;
      end else begin
        r_state  <= w_state_nx;
        r_cnt    <= w_cnt_nx;
        r_dm     <= w_dm_nx;
        r_clk    <= w_clk_nx;
        r_clk_en <= w_clk_en_nx;
        r_run    <= w_run_nx;
      end
    end

    assign o_clk[c]     = r_clk;
    assign o_clk_en[c]  = r_clk_en;
    assign o_running[c] = r_run;
  end

endmodule

// File: tb/tb_dsp_fe_clkdiv_multi.sv
// Directed bench for dsp_fe_clkdiv_multi with
// hand-computed per-cycle patterns.
module tb_dsp_fe_clkdiv_multi;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [15:0] div;
  logic        sync;
  logic [3:0]  o_clk;
  logic [3:0]  o_clk_en;
  logic [3:0]  o_running;

  int checks;
  int failures;

  dsp_fe_clkdiv_multi #(.NumCh(4), .DivWidth(4)) dut (
    .i_clk_ref (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_div     (div),
    .i_sync    (sync),
    .o_clk     (o_clk),
    .o_clk_en  (o_clk_en),
    .o_running (o_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n ticks on one channel; bit n-1-i of each pattern is tick i
  task automatic seq(input string tag, input int ch, input int n,
                     input logic [31:0] cp, input logic [31:0] ep);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_clk"}, 32'(o_clk[ch]), 32'(cp[n-1-i]));
      check({tag, "_en"}, 32'(o_clk_en[ch]), 32'(ep[n-1-i]));
    end
  endtask

  task automatic ch3(input string tag, input int ch,
                     input logic c, input logic e, input logic r);
    check({tag, "_clk"}, 32'(o_clk[ch]), 32'(c));
    check({tag, "_en"}, 32'(o_clk_en[ch]), 32'(e));
    check({tag, "_run"}, 32'(o_running[ch]), 32'(r));
  endtask

  initial begin
    logic [9:0] p0c, p0e, p1c, p1e;
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    en   = 4'b0000;
    div  = 16'h0000;
    sync = 1'b0;

    tick();
    check("rst_clk", 32'(o_clk), 32'h0);
    check("rst_en", 32'(o_clk_en), 32'h0);
    check("rst_run", 32'(o_running), 32'h0);

    // en requested while reset still held
    en  = 4'b0001;
    div = 16'h0003;
    tick();
    check("rst_hold_run", 32'(o_running), 32'h0);

    // release: R=4 gives 1100, strobe every 4th
    rst = 1'b0;
    seq("r4", 0, 8, 32'b11001100, 32'b00010001);
    check("r4_others", 32'(o_running[3:1]), 32'h0);
    seq("r4b", 0, 2, 32'b11, 32'b00);

    // ratio change at cnt=1 takes effect after the wrap
    div = 16'h0001;
    seq("chg", 0, 6, 32'b001010, 32'b010101);

    // D=0 behaves as D=1
    div = 16'h0000;
    seq("d0", 0, 4, 32'b1010, 32'b0101);

    // stop request at cnt=1 completes the period
    div = 16'h0003;
    tick(); ch3("stA0", 0, 1, 0, 1);
    tick(); ch3("stA1", 0, 1, 0, 1);
    en = 4'b0000;
    tick(); ch3("stA2", 0, 0, 0, 1);
    tick(); ch3("stA3", 0, 0, 1, 1);
    tick(); ch3("stA4", 0, 0, 0, 0);

    // stop then re-raise before the wrap
    en = 4'b0001;
    tick(); ch3("stB0", 0, 1, 0, 1);
    tick(); ch3("stB1", 0, 1, 0, 1);
    en = 4'b0000;
    tick(); ch3("stB2", 0, 0, 0, 1);
    en = 4'b0001;
    tick(); ch3("stB3", 0, 0, 1, 1);
    tick(); ch3("stB4", 0, 1, 0, 1);

    // ch0 R=5, ch1 R=3, then sync aligns them
    div = 16'h0024;
    en  = 4'b0011;
    tick();
    tick();
    sync = 1'b1;
    p0c = 10'b1100011000;
    p0e = 10'b0000100001;
    p1c = 10'b1001001001;
    p1e = 10'b0010010010;
    for (int i = 0; i < 10; i++) begin
      tick();
      sync = 1'b0;
      check("sy_c0", 32'(o_clk[0]), 32'(p0c[9-i]));
      check("sy_e0", 32'(o_clk_en[0]), 32'(p0e[9-i]));
      check("sy_c1", 32'(o_clk[1]), 32'(p1c[9-i]));
      check("sy_e1", 32'(o_clk_en[1]), 32'(p1e[9-i]));
    end
    check("sy_idle_run", 32'(o_running[3:2]), 32'h0);
    check("sy_idle_clk", 32'(o_clk[3:2]), 32'h0);

    // sync with en falling on ch1: one full period then idle
    en   = 4'b0001;
    sync = 1'b1;
    tick(); ch3("syst0", 1, 1, 0, 1);
    check("syst0_c0", 32'(o_clk[0]), 32'h1);
    sync = 1'b0;
    tick(); ch3("syst1", 1, 0, 0, 1);
    tick(); ch3("syst2", 1, 0, 1, 1);
    tick(); ch3("syst3", 1, 0, 0, 0);

    // sync coincident with ch0 wrap
    tick(); ch3("syw0", 0, 0, 1, 1);
    sync = 1'b1;
    tick(); ch3("syw1", 0, 1, 0, 1);
    sync = 1'b0;
    tick(); ch3("syw2", 0, 1, 0, 1);
    tick(); ch3("syw3", 0, 0, 0, 1);

    // move ch0 to R=8, then reset at cnt=1
    div = 16'h0007;
    tick();
    tick(); ch3("r8pre", 0, 0, 1, 1);
    tick(); ch3("r8c0", 0, 1, 0, 1);
    tick(); ch3("r8c1", 0, 1, 0, 1);
    rst  = 1'b1;
    sync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      sync = 1'b0;
      check("mrst_clk", 32'(o_clk), 32'h0);
      check("mrst_en", 32'(o_clk_en), 32'h0);
      check("mrst_run", 32'(o_running), 32'h0);
    end
    rst = 1'b0;
    seq("r8", 0, 8, 32'b11110000, 32'b00000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
